// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared definitions for the 4-digit seven-segment display stage.
//   - Active-low segment codes {dp,g,f,e,d,c,b,a} for digits, dash and blank.
//   - Conversion FSM state enum (IDLE, SHIFT, COMMIT).
//   - BCD width helper, double-dabble nibble adjust and segment decode functions.
// Optional feature macro used by the files of this slice: SEVENSEG_SCAN_DP_EN.
package sevenseg_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_t;

  function automatic int unsigned bcd_width(input int unsigned digits);
    return 32'd4 * digits;
  endfunction

  localparam int unsigned      BIN_W      = 14;
  localparam int unsigned      BCD_W      = bcd_width(32'd4);
  localparam logic [BIN_W-1:0] MAX_VALUE  = 14'd9999;
  localparam logic [3:0]       SHIFT_LAST = 4'd13;
  // Every nibble 0xF: no valid BCD digit, decodes to a dash and is never a leading zero.
  localparam logic [BCD_W-1:0] BCD_OVF    = 16'hFFFF;

  function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
    return (nib >= 4'd5) ? (nib + 4'd3) : nib;
  endfunction

  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter with a one-deep pending slot.
// Ports:
//   FPGA_CLK, RESET_BUT  clock, synchronous active-high reset
//   start, value         one-cycle strobe and 14-bit binary value
//   dp_in, dp_out        decimal points carried with the value (SEVENSEG_SCAN_DP_EN only)
//   busy                 registered, high while a conversion is in flight
//   done                 high during COMMIT; bcd/dp_out are valid then
//   bcd                  conversion result, BCD_OVF for inputs above 9999
module bin2bcd_seq
  import sevenseg_pkg::*;
(
  input  logic             FPGA_CLK,
  input  logic             RESET_BUT,
  input  logic             start,
  input  logic [BIN_W-1:0] value,
`ifdef SEVENSEG_SCAN_DP_EN
  input  logic [3:0]       dp_in,
  output logic [3:0]       dp_out,
`endif
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  conv_state_t      state_r, state_nxt_s;
  logic             busy_r, pend_r, load_s, take_pend_s, ovf_s;
  logic [BIN_W-1:0] pend_val_r, load_val_s, bin_r;
  logic [BCD_W-1:0] acc_r, acc_adj_s;
  logic [3:0]       cnt_r;
`ifdef SEVENSEG_SCAN_DP_EN
  logic [3:0]       pend_dp_r, load_dp_s, dp_r;
`endif

  // Next state and load selection; a strobe arriving in COMMIT starts at once and beats the pending slot.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    take_pend_s = 1'b0;
    load_val_s  = value;
`ifdef SEVENSEG_SCAN_DP_EN
    load_dp_s   = dp_in;
`endif
    case (state_r)
      IDLE: begin
        if (start) begin
          load_s      = 1'b1;
          state_nxt_s = (value > MAX_VALUE) ? COMMIT : SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == SHIFT_LAST) begin
          state_nxt_s = COMMIT;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      COMMIT: begin
        if (start) begin
          load_s      = 1'b1;
          take_pend_s = 1'b1;
          state_nxt_s = (value > MAX_VALUE) ? COMMIT : SHIFT;
        end else if (pend_r) begin
          load_s      = 1'b1;
          take_pend_s = 1'b1;
          load_val_s  = pend_val_r;
`ifdef SEVENSEG_SCAN_DP_EN
          load_dp_s   = pend_dp_r;
`endif
          state_nxt_s = (pend_val_r > MAX_VALUE) ? COMMIT : SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
    ovf_s = (load_val_s > MAX_VALUE);
  end

  // Per-nibble add-3 correction applied before each shift.
  always_comb begin
    acc_adj_s = {BCD_W{1'b0}};
    for (int i = 0; i < int'(BCD_W / 32'd4); i++) begin
      acc_adj_s[i*4 +: 4] = dabble_adj(acc_r[i*4 +: 4]);
    end
  end

  // State register; busy is registered from the next state so it rises the cycle after start.
  always_ff @(posedge FPGA_CLK) begin
    if (RESET_BUT) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
    end
  end

  // Working registers: load on start, then one dabble-and-shift step per SHIFT cycle.
  always_ff @(posedge FPGA_CLK) begin
    if (RESET_BUT) begin
      acc_r <= {BCD_W{1'b0}};
      bin_r <= {BIN_W{1'b0}};
      cnt_r <= 4'd0;
    end else if (load_s) begin
      cnt_r <= 4'd0;
      if (ovf_s) begin
        acc_r <= BCD_OVF;
        bin_r <= {BIN_W{1'b0}};
      end else begin
        acc_r <= {BCD_W{1'b0}};
        bin_r <= load_val_s;
      end
    end else if (state_r == SHIFT) begin
      {acc_r, bin_r} <= {acc_adj_s, bin_r} << 1;
      cnt_r          <= cnt_r + 4'd1;
    end
  end

  // Pending slot: a strobe that cannot start immediately waits here, the newest overwriting older ones.
  always_ff @(posedge FPGA_CLK) begin
    if (RESET_BUT) begin
      pend_r     <= 1'b0;
      pend_val_r <= {BIN_W{1'b0}};
    end else if (start && !load_s) begin
      pend_r     <= 1'b1;
      pend_val_r <= value;
    end else if (take_pend_s) begin
      pend_r     <= 1'b0;
    end
  end

`ifdef SEVENSEG_SCAN_DP_EN
  // Decimal points travel with their value through the pending slot and the working register.
  always_ff @(posedge FPGA_CLK) begin
    if (RESET_BUT) begin
      pend_dp_r <= 4'd0;
      dp_r      <= 4'd0;
    end else begin
      if (start && !load_s) begin
        pend_dp_r <= dp_in;
      end
      if (load_s) begin
        dp_r <= load_dp_s;
      end
    end
  end

  assign dp_out = dp_r;
`endif

  assign busy = busy_r;
  assign done = (state_r == COMMIT);
  assign bcd  = acc_r;

endmodule

// File: rtl/sevenseg_scan4.sv
// sevenseg_scan4: binary-to-BCD conversion plus 4-digit multiplexed common-anode display driver.
// Ports:
//   FPGA_CLK, RESET_BUT  clock, synchronous active-high reset
//   data_in, data_valid  value to show (0..9999, larger shows dashes) and its load strobe
//   dp_in                active-high decimal points, dp_in[3] on DIG_1 (SEVENSEG_SCAN_DP_EN only)
//   lz_blank             1 = blank leading zeros, sampled every cycle
//   busy                 conversion in progress
//   DIG                  active-low digit enables, DIG[0] = thousands .. DIG[3] = units
//   SEG                  active-low {dp,g,f,e,d,c,b,a}
// Optional feature macro: SEVENSEG_SCAN_DP_EN (decimal point input).
module sevenseg_scan4
  import sevenseg_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned SCAN_HZ   = 1000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic             FPGA_CLK,
  input  logic             RESET_BUT,
  input  logic [BIN_W-1:0] data_in,
  input  logic             data_valid,
`ifdef SEVENSEG_SCAN_DP_EN
  input  logic [3:0]       dp_in,
`endif
  input  logic             lz_blank,
  output logic             busy,
  output logic [3:0]       DIG,
  output logic [7:0]       SEG
);

  localparam int unsigned       SCAN_PERIOD = CLK_HZ / SCAN_HZ;
  localparam int unsigned       TICK_W      = $clog2(SCAN_PERIOD);
  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(SCAN_PERIOD - 32'd1);
  localparam logic [TICK_W-1:0] TICK_BLANK  = TICK_W'(BLANK_CYC);
  localparam logic [TICK_W-1:0] TICK_ONE    = TICK_W'(32'd1);

  logic [TICK_W-1:0] tick_r;
  logic [1:0]        idx_r;
  logic [BCD_W-1:0]  disp_bcd_r, conv_bcd_s;
  logic              conv_done_s, lead_s, dp_bit_s;
  logic [3:0]        dig_r, dig_nxt_s, nib_s;
  logic [7:0]        seg_r, seg_nxt_s;
`ifdef SEVENSEG_SCAN_DP_EN
  logic [3:0]        conv_dp_s, disp_dp_r;
`endif

  bin2bcd_seq u_conv (
    .FPGA_CLK  (FPGA_CLK),
    .RESET_BUT (RESET_BUT),
    .start     (data_valid),
    .value     (data_in),
`ifdef SEVENSEG_SCAN_DP_EN
    .dp_in     (dp_in),
    .dp_out    (conv_dp_s),
`endif
    .busy      (busy),
    .done      (conv_done_s),
    .bcd       (conv_bcd_s)
  );

  // Display register only changes on a completed conversion, so the shown value never tears.
  always_ff @(posedge FPGA_CLK) begin
    if (RESET_BUT) begin
      disp_bcd_r <= {BCD_W{1'b0}};
`ifdef SEVENSEG_SCAN_DP_EN
      disp_dp_r  <= 4'd0;
`endif
    end else if (conv_done_s) begin
      disp_bcd_r <= conv_bcd_s;
`ifdef SEVENSEG_SCAN_DP_EN
      disp_dp_r  <= conv_dp_s;
`endif
    end
  end

  // Refresh tick counter; each wrap moves the scan to the next digit.
  always_ff @(posedge FPGA_CLK) begin
    if (RESET_BUT) begin
      tick_r <= {TICK_W{1'b0}};
      idx_r  <= 2'd0;
    end else if (tick_r == TICK_LAST) begin
      tick_r <= {TICK_W{1'b0}};
      idx_r  <= idx_r + 2'd1;
    end else begin
      tick_r <= tick_r + TICK_ONE;
    end
  end

  // Digit select, leading-zero detection and decode; all digits dark during the anti-ghosting window.
  always_comb begin
    dig_nxt_s = 4'b1111;
    seg_nxt_s = SEG_BLANK;
    nib_s     = 4'd0;
    lead_s    = 1'b0;
    dp_bit_s  = 1'b0;
    case (idx_r)
      2'd0: begin
        nib_s  = disp_bcd_r[15:12];
        lead_s = (disp_bcd_r[15:12] == 4'd0);
      end
      2'd1: begin
        nib_s  = disp_bcd_r[11:8];
        lead_s = (disp_bcd_r[15:8] == 8'd0);
      end
      2'd2: begin
        nib_s  = disp_bcd_r[7:4];
        lead_s = (disp_bcd_r[15:4] == 12'd0);
      end
      default: begin
        // Units digit is always shown, even for a value of zero.
        nib_s  = disp_bcd_r[3:0];
        lead_s = 1'b0;
      end
    endcase
`ifdef SEVENSEG_SCAN_DP_EN
    dp_bit_s = disp_dp_r[2'd3 - idx_r];
`endif
    if (tick_r < TICK_BLANK) begin
      dig_nxt_s = 4'b1111;
      seg_nxt_s = SEG_BLANK;
    end else begin
      dig_nxt_s = ~(4'b0001 << idx_r);
      if (lz_blank && lead_s) begin
        seg_nxt_s = SEG_BLANK;
      end else begin
        seg_nxt_s = seg_decode(nib_s);
      end
      seg_nxt_s[7] = ~dp_bit_s;
    end
  end

  // Registered pin drivers.
  always_ff @(posedge FPGA_CLK) begin
    if (RESET_BUT) begin
      dig_r <= 4'b1111;
      seg_r <= SEG_BLANK;
    end else begin
      dig_r <= dig_nxt_s;
      seg_r <= seg_nxt_s;
    end
  end

  assign DIG = dig_r;
  assign SEG = seg_r;

endmodule
